tone_sweep_sequencer: RTL and testbench

TONE_SWEEP_SEQUENCER -- requirements
Module: tone_sweep_sequencer

---
 rtl/tone_sweep_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_tone_sweep_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sweep_sequencer.sv
// Steps a CORDIC tone generator through a fixed 12-tone table, lets each tone settle,
// then reports the peak |s_in| seen during a measurement window through a valid/ready handshake.
module tone_sweep_sequencer #(
    parameter int IW         = 16,
    parameter int FW         = 21,
    parameter int SETTLE_CYC = 4096,
    parameter int MEAS_CYC   = 8192
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    output logic [IW-1:0]        phase_inc,
    output logic                 gen_rst,
    input  logic signed [FW-1:0] s_in,
    output logic [3:0]           res_idx,
    output logic [FW-2:0]        res_peak,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int MAXC = (SETTLE_CYC > MEAS_CYC) ? SETTLE_CYC : MEAS_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] MEAS_LAST   = CW'(MEAS_CYC - 1);
    localparam logic [3:0]    LAST_IDX    = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_MEASURE,
        S_REPORT
    } state_t;

    function automatic logic [IW-1:0] tone_inc(input logic [3:0] i);
        case (i)
            4'd0:    tone_inc = IW'(215);
            4'd1:    tone_inc = IW'(429);
            4'd2:    tone_inc = IW'(644);
            4'd3:    tone_inc = IW'(858);
            4'd4:    tone_inc = IW'(1073);
            4'd5:    tone_inc = IW'(1287);
            4'd6:    tone_inc = IW'(1514);
            4'd7:    tone_inc = IW'(1716);
            4'd8:    tone_inc = IW'(1907);
            4'd9:    tone_inc = IW'(2145);
            4'd10:   tone_inc = IW'(2340);
            4'd11:   tone_inc = IW'(2574);
            default: tone_inc = '0;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-2:0] peak_q, peak_d;
    logic [IW-1:0] phase_inc_q, phase_inc_d;
    logic          gen_rst_q, gen_rst_d;
    logic [3:0]    res_idx_q, res_idx_d;
    logic [FW-2:0] res_peak_q, res_peak_d;
    logic          res_valid_q, res_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // |s_in| with the single negative-only code clamped to the largest positive magnitude
    logic [FW-1:0] s_neg;
    logic [FW-2:0] mag;
    logic [FW-2:0] peak_max;

    always_comb begin
        s_neg = FW'(-s_in);
        if (s_in == {1'b1, {(FW-1){1'b0}}})
            mag = '1;
        else if (s_in[FW-1])
            mag = s_neg[FW-2:0];
        else
            mag = s_in[FW-2:0];
        peak_max = (mag > peak_q) ? mag : peak_q;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        peak_d      = peak_q;
        phase_inc_d = phase_inc_q;
        gen_rst_d   = 1'b0;
        res_idx_d   = res_idx_q;
        res_peak_d  = res_peak_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    idx_d       = 4'd0;
                    phase_inc_d = tone_inc(4'd0);
                    gen_rst_d   = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                    peak_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MEASURE: begin
                peak_d = peak_max;
                if (cnt_q == MEAS_LAST) begin
                    state_d     = S_REPORT;
                    cnt_d       = '0;
                    res_valid_d = 1'b1;
                    res_idx_d   = idx_q;
                    res_peak_d  = peak_max;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (idx_q != LAST_IDX) begin
                        state_d     = S_LOAD;
                        idx_d       = idx_q + 4'd1;
                        phase_inc_d = tone_inc(idx_q + 4'd1);
                        gen_rst_d   = 1'b1;
                    end else if (continuous) begin
                        state_d     = S_LOAD;
                        idx_d       = 4'd0;
                        phase_inc_d = tone_inc(4'd0);
                        gen_rst_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            peak_q      <= '0;
            phase_inc_q <= '0;
            gen_rst_q   <= 1'b0;
            res_idx_q   <= '0;
            res_peak_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            peak_q      <= peak_d;
            phase_inc_q <= phase_inc_d;
            gen_rst_q   <= gen_rst_d;
            res_idx_q   <= res_idx_d;
            res_peak_q  <= res_peak_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign phase_inc = phase_inc_q;
    assign gen_rst   = gen_rst_q;
    assign res_idx   = res_idx_q;
    assign res_peak  = res_peak_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tone_sweep_sequencer.sv
// Bench for tone_sweep_sequencer: a per-tone timeline model (offset since LOAD) checked every cycle,
// plus directed sweeps with literal expectations for peaks, timing, stalls, continuous mode and reset.
module tb_tone_sweep_sequencer;
    localparam int IW = 16;
    localparam int FW = 21;
    localparam int S  = 4;
    localparam int M  = 8;
    localparam int PMAX = (1 << (FW-1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic res_ready = 1'b0;
    logic signed [FW-1:0] s_in;
    logic [IW-1:0] phase_inc;
    logic gen_rst;
    logic [3:0] res_idx;
    logic [FW-2:0] res_peak;
    logic res_valid, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    int sweep_no = 0;
    int tones [12] = '{215, 429, 644, 858, 1073, 1287, 1514, 1716, 1907, 2145, 2340, 2574};
    int exp_pk [12];
    int pattern [4] = '{5, -300, 40, -7};

    always #5 clk = ~clk;

    tone_sweep_sequencer #(.IW(IW), .FW(FW), .SETTLE_CYC(S), .MEAS_CYC(M)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .phase_inc(phase_inc), .gen_rst(gen_rst), .s_in(s_in),
        .res_idx(res_idx), .res_peak(res_peak), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .done(done)
    );

    // Model: offset 0 is the LOAD cycle, 1..S settle, S+1..S+M measure, S+M+1 onward reporting.
    bit m_active, m_gen_rst, m_valid, m_done;
    int m_idx, m_off, m_phase, m_peak, m_res_idx, m_res_peak;

    function automatic int sat_abs(input int v);
        int a;
        a = (v < 0) ? -v : v;
        if (a > PMAX) a = PMAX;
        return a;
    endfunction

    task automatic begin_tone(input int i);
        m_active = 1; m_idx = i; m_off = 0; m_phase = tones[i]; m_gen_rst = 1;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_active = 0; m_idx = 0; m_off = 0; m_phase = 0; m_gen_rst = 0;
            m_valid = 0; m_res_idx = 0; m_res_peak = 0; m_done = 0; m_peak = 0;
        end else begin
            m_gen_rst = 0;
            m_done = 0;
            if (!m_active) begin
                if (start) begin_tone(0);
            end else if (m_valid) begin
                if (res_ready) begin
                    m_valid = 0;
                    if (m_idx < 11) begin_tone(m_idx + 1);
                    else if (continuous) begin_tone(0);
                    else begin m_active = 0; m_done = 1; end
                end
            end else begin
                if (m_off >= S+1 && m_off <= S+M) begin
                    if (m_off == S+1) m_peak = sat_abs(int'(s_in));
                    else if (sat_abs(int'(s_in)) > m_peak) m_peak = sat_abs(int'(s_in));
                end
                m_off++;
                if (m_off == 1+S+M) begin
                    m_valid = 1; m_res_idx = m_idx; m_res_peak = m_peak;
                end
            end
        end
    end

    function automatic int sval(input int sw, input int idx, input int off);
        if (sw == 0) return 100;
        if (sw == 1) begin
            case (idx)
                0: return pattern[off % 4];
                1: return -(1 << (FW-1));
                2: return (off >= 1 && off <= S) ? 9000 : 50;
                3: return (off == S+1) ? 666 : 10;
                4: return (off == S+M) ? 777 : -10;
                5: return (off == S || off > S+M) ? 9999 : 20;
                default: return int'($urandom_range(0, (1 << FW) - 1)) - (1 << (FW-1));
            endcase
        end
        return idx * 37 - 200;
    endfunction

    always @(negedge clk) s_in = FW'(sval(sweep_no, m_idx, m_off));

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (phase_inc !== IW'(m_phase) || gen_rst !== m_gen_rst || res_valid !== m_valid ||
                res_idx !== 4'(m_res_idx) || res_peak !== (FW-1)'(m_res_peak) ||
                busy !== m_active || done !== m_done) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got ph=%0d gr=%b v=%b idx=%0d pk=%0d busy=%b done=%b, need ph=%0d gr=%b v=%b idx=%0d pk=%0d busy=%b done=%b",
                         $time, phase_inc, gen_rst, res_valid, res_idx, res_peak, busy, done,
                         m_phase, m_gen_rst, m_valid, m_res_idx, m_res_peak, m_active, m_done);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, need %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " phase_inc"}, 32'(phase_inc), 0);
        chk({tag, " gen_rst"}, 32'(gen_rst), 0);
        chk({tag, " res_valid"}, 32'(res_valid), 0);
        chk({tag, " res_idx"}, 32'(res_idx), 0);
        chk({tag, " res_peak"}, 32'(res_peak), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
    endtask

    // Full sweep with res_ready high; exp_pk[i] < 0 leaves that tone to the model only.
    task automatic run_sweep(input string tag);
        int nres, ndone, t_load, t_prev;
        nres = 0; ndone = 0; t_load = 0; t_prev = 0;
        res_ready = 1; continuous = 0;
        start = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == 0 || c == 33) start = 0;
            if (c == 30) start = 1;
            if (gen_rst) begin
                t_load = c;
                chk({tag, " load phase_inc"}, 32'(phase_inc), 32'(tones[nres % 12]));
            end
            if (res_valid && res_ready) begin
                chk({tag, " res_idx"}, 32'(res_idx), 32'(nres));
                if (nres < 12 && exp_pk[nres] >= 0)
                    chk({tag, " res_peak"}, 32'(res_peak), 32'(exp_pk[nres]));
                if (nres == 0) chk({tag, " latency"}, 32'(c - t_load), 13);
                else chk({tag, " spacing"}, 32'(c - t_prev), 14);
                t_prev = c;
                nres++;
            end
            if (done) ndone++;
            if (nres == 12 && !busy) break;
        end
        start = 0;
        chk({tag, " result count"}, 32'(nres), 12);
        chk({tag, " done pulses"}, 32'(ndone), 1);
        chk({tag, " busy after"}, 32'(busy), 0);
    endtask

    initial begin
        int found, ndone;
        rst = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk_zero_outputs("reset");
        rst = 1;
        @(negedge clk);

        sweep_no = 0;
        for (int i = 0; i < 12; i++) exp_pk[i] = 100;
        run_sweep("const");

        sweep_no = 1;
        exp_pk = '{300, PMAX, 50, 666, 777, 20, -1, -1, -1, -1, -1, -1};
        run_sweep("pattern");

        // Stall the first result for 20 cycles, then switch to continuous mode.
        sweep_no = 2;
        res_ready = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 60 && !res_valid; c++) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            chk("stall res_valid", 32'(res_valid), 1);
            chk("stall res_idx", 32'(res_idx), 0);
            chk("stall res_peak", 32'(res_peak), 200);
            @(negedge clk);
        end
        continuous = 1;
        res_ready = 1;
        @(negedge clk);
        chk("after stall gen_rst", 32'(gen_rst), 1);
        chk("after stall phase_inc", 32'(phase_inc), 429);
        chk("after stall res_valid", 32'(res_valid), 0);
        found = 0; ndone = 0;
        for (int c = 0; c < 400 && found == 0; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (res_valid && res_ready && res_idx == 4'd11) begin
                @(negedge clk);
                found = 1;
                chk("wrap gen_rst", 32'(gen_rst), 1);
                chk("wrap phase_inc", 32'(phase_inc), 215);
                chk("wrap done", 32'(done), 0);
                chk("wrap busy", 32'(busy), 1);
            end
        end
        chk("wrap reached", 32'(found), 1);
        chk("continuous done pulses", 32'(ndone), 0);

        // Reset in the middle of the tone-5 measurement window.
        found = 0;
        for (int c = 0; c < 400; c++) begin
            if (m_idx == 5 && m_off == S+3) begin found = 1; break; end
            @(negedge clk);
        end
        chk("tone5 measure reached", 32'(found), 1);
        rst = 0;
        @(negedge clk);
        chk_zero_outputs("midreset");
        @(negedge clk);
        rst = 1;
        continuous = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post-reset res_valid", 32'(res_valid), 0);
            chk("post-reset done", 32'(done), 0);
            chk("post-reset busy", 32'(busy), 0);
        end
        sweep_no = 0;
        for (int i = 0; i < 12; i++) exp_pk[i] = 100;
        run_sweep("restart");

        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
